// File: rtl/reg_reader.sv
// Read-side register sequencer: on go, reads BASE then COUNT registers up or down,
// presenting each word on data/data_valid and accumulating a running sum.
module reg_reader #(
  parameter int WIDTH = 32,
  parameter int BASE  = 8,
  parameter int COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             direction,
  input  logic [WIDTH-1:0] rd_data,
  output logic [4:0]       regnum,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic [WIDTH-1:0] sum,
  output logic             done
);

  localparam logic [4:0] BASE5  = BASE[4:0];
  localparam logic [3:0] COUNT4 = COUNT[3:0];

  typedef enum logic [1:0] {Idle, Start, Read, Done} state_t;

  state_t     state, nextState;
  logic [3:0] k;
  logic       dirLatch;
  logic       leaveStart, capture, enterStart;

  assign leaveStart = (state == Start) && !go;
  assign capture    = leaveStart || (state == Read);
  assign enterStart = ((state == Idle) || (state == Done)) && go;
  assign done       = (state == Done);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= Idle;
      k          <= '0;
      dirLatch   <= 1'b0;
      data       <= '0;
      sum        <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= nextState;
      data_valid <= capture;
      if (capture) data <= rd_data;
      if (enterStart) begin
        sum <= '0;
      end else if (leaveStart) begin
        dirLatch <= direction;
        sum      <= rd_data;
        k        <= 4'd1;
      end else if (state == Read) begin
        // carry out of the top bit is intentionally dropped
        sum <= sum + rd_data;
        k   <= k + 4'd1;
      end
    end
  end

  always_comb begin
    nextState = state;
    regnum    = '0;
    case (state)
      Idle:  if (go) nextState = Start;
      Start: begin
        regnum = BASE5;
        if (!go) nextState = Read;
      end
      Read: begin
        regnum = dirLatch ? BASE5 + {1'b0, k} : BASE5 - {1'b0, k};
        if (k == COUNT4) nextState = Done;
      end
      Done:  if (go) nextState = Start;
      default: nextState = Idle;
    endcase
  end

endmodule
